// File: rtl/instr_fetch_responder_pkg.sv
// Shared constants for the instruction fetch responder: FSM encodings and word offset.
package instr_fetch_responder_pkg;

    localparam int WORD_OFF = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

endpackage

// File: rtl/instr_fetch_responder_tag_store.sv
// Direct-mapped word buffer: valid/tag/data flops with a combinational lookup,
// one write port and a clear-all that takes priority over a same-cycle write.
module fetch_tag_store #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 57
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    input  logic [TAG_W-1:0]      i_rd_tag,
    output logic                  o_rd_hit,
    output logic [63:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [63:0]           i_wr_data,
    input  logic                  i_clr
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]             r_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
    logic [ENTRIES-1:0][63:0]       r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetch-side instruction responder: zero-latency hits from a small direct-mapped
// buffer, stall plus valid/ready bus refill on a miss.
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_read_in,
    input  logic [ADDR_W-1:0] instr_address_in,
    output logic [63:0]       instr_read_value_out,
    output logic              instr_stall_out,
    output logic              instr_fault_out,
    input  logic              invalidate_in,
    output logic              mem_req_valid_out,
    input  logic              mem_req_ready_in,
    output logic [ADDR_W-1:0] mem_req_addr_out,
    input  logic              mem_resp_valid_in,
    input  logic [63:0]       mem_resp_data_in,
    input  logic              mem_resp_err_in
);

    localparam int TAG_W = ADDR_W - WORD_OFF - INDEX_BITS;

    logic [1:0]            r_state;
    logic [ADDR_W-1:0]     r_miss_addr;
    logic                  r_drop;
    logic                  r_fault;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_st_hit;
    logic [63:0]           w_st_data;
    logic                  w_hit;
    logic                  w_wr_en;
    logic                  w_unused;

    assign w_idx    = instr_address_in[WORD_OFF +: INDEX_BITS];
    assign w_tag    = instr_address_in[ADDR_W-1 : WORD_OFF+INDEX_BITS];
    assign w_unused = ^instr_address_in[WORD_OFF-1:0];

    // Invalidate in IDLE forces a miss so no stale word escapes in the fence cycle.
    assign w_hit = instr_read_in && w_st_hit && (r_state == ST_IDLE) && !invalidate_in;

    assign instr_stall_out      = instr_read_in && !w_hit;
    assign instr_read_value_out = w_hit ? w_st_data : 64'd0;
    assign instr_fault_out      = r_fault;
    assign mem_req_valid_out    = (r_state == ST_REQ);
    assign mem_req_addr_out     = r_miss_addr;

    assign w_wr_en = (r_state == ST_WAIT) && mem_resp_valid_in && !mem_resp_err_in && !r_drop;

    fetch_tag_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_idx  (w_idx),
        .i_rd_tag  (w_tag),
        .o_rd_hit  (w_st_hit),
        .o_rd_data (w_st_data),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_miss_addr[WORD_OFF +: INDEX_BITS]),
        .i_wr_tag  (r_miss_addr[ADDR_W-1 : WORD_OFF+INDEX_BITS]),
        .i_wr_data (mem_resp_data_in),
        .i_clr     (invalidate_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_miss_addr <= '0;
            r_drop      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_read_in && !w_hit && !invalidate_in) begin
                        r_miss_addr <= {instr_address_in[ADDR_W-1:WORD_OFF], {WORD_OFF{1'b0}}};
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (invalidate_in) r_drop <= 1'b1;
                    if (mem_req_ready_in) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (invalidate_in) r_drop <= 1'b1;
                    if (mem_resp_valid_in) begin
                        r_fault <= mem_resp_err_in;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Lookup is redone in IDLE against whatever PC fetch presents now.
                    r_drop  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench: driver pushes expected bus requests, words and faults; a
// negedge monitor pops and compares as the DUT presents them.
module tb_instr_fetch_responder;

    logic        clk;
    logic        rst_n;
    logic        instr_read_in;
    logic [63:0] instr_address_in;
    logic [63:0] instr_read_value_out;
    logic        instr_stall_out;
    logic        instr_fault_out;
    logic        invalidate_in;
    logic        mem_req_valid_out;
    logic        mem_req_ready_in;
    logic [63:0] mem_req_addr_out;
    logic        mem_resp_valid_in;
    logic [63:0] mem_resp_data_in;
    logic        mem_resp_err_in;

    instr_fetch_responder #(.INDEX_BITS(4), .ADDR_W(64)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_stall_out      (instr_stall_out),
        .instr_fault_out      (instr_fault_out),
        .invalidate_in        (invalidate_in),
        .mem_req_valid_out    (mem_req_valid_out),
        .mem_req_ready_in     (mem_req_ready_in),
        .mem_req_addr_out     (mem_req_addr_out),
        .mem_resp_valid_in    (mem_resp_valid_in),
        .mem_resp_data_in     (mem_resp_data_in),
        .mem_resp_err_in      (mem_resp_err_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_req[$];
    logic [63:0] exp_val[$];
    int          exp_flt = 0;

    int resp_lat  = 1;
    int err_tok   = 0;
    int stray_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=present required=none", name);
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h1000) return 64'h00000013_00000013;
        return {a[31:0], ~a[31:0]};
    endfunction

    // Bus responder: answers each accepted request resp_lat cycles later.
    initial begin
        int          cnt;
        bit          pend;
        logic [63:0] baddr;
        int          err_used;
        int          stray_done;
        cnt = 0; pend = 0; baddr = '0; err_used = 0; stray_done = 0;
        mem_resp_valid_in = 1'b0;
        mem_resp_data_in  = '0;
        mem_resp_err_in   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 0;
            else if (mem_req_valid_out && mem_req_ready_in) begin
                pend = 1; cnt = resp_lat; baddr = mem_req_addr_out;
            end
            @(posedge clk); #1;
            mem_resp_valid_in = 1'b0;
            mem_resp_err_in   = 1'b0;
            if (!rst_n) pend = 0;
            if (stray_cnt != stray_done) begin
                stray_done++;
                mem_resp_valid_in = 1'b1;
                mem_resp_data_in  = 64'hDEADBEEF_DEADBEEF;
            end else if (pend) begin
                if (cnt <= 1) begin
                    pend = 0;
                    mem_resp_valid_in = 1'b1;
                    mem_resp_data_in  = mem_word(baddr);
                    if (err_tok != err_used) begin
                        err_used++;
                        mem_resp_err_in = 1'b1;
                    end
                end else cnt--;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req_valid_out) begin
                    if (exp_req.size() == 0) unexpected("req");
                    else begin
                        chk("req_addr", mem_req_addr_out, exp_req[0]);
                        if (mem_req_ready_in) void'(exp_req.pop_front());
                    end
                end
                if (instr_read_in && !instr_stall_out) begin
                    if (exp_val.size() == 0) unexpected("value");
                    else chk("value", instr_read_value_out, exp_val.pop_front());
                end
                if (instr_fault_out) begin
                    if (exp_flt == 0) unexpected("fault");
                    else begin
                        checks++;
                        exp_flt--;
                    end
                end
            end
        end
    end

    task automatic wait_hit(output int n);
        bit done;
        n = 0; done = 0;
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            if (!instr_stall_out) done = 1;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        if (!done) unexpected("hit_timeout");
    endtask

    task automatic fetch(input logic [63:0] a, output int n);
        instr_address_in = a;
        instr_read_in    = 1'b1;
        wait_hit(n);
        @(posedge clk); #1;
        instr_read_in = 1'b0;
    endtask

    initial begin
        int n;
        bit got;
        rst_n = 1'b0; instr_read_in = 1'b0; instr_address_in = '0;
        invalidate_in = 1'b0; mem_req_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {63'd0, instr_stall_out}, 64'd0);
        chk("rst_req_valid", {63'd0, mem_req_valid_out}, 64'd0);
        chk("rst_fault", {63'd0, instr_fault_out}, 64'd0);
        chk("rst_value", instr_read_value_out, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: cold miss
        exp_req.push_back(64'h1000); exp_val.push_back(64'h00000013_00000013);
        fetch(64'h1000, n); chk("cold_stall_cycles", n, 4);

        // 2: hit, then same-index conflicts
        exp_val.push_back(64'h00000013_00000013);
        fetch(64'h1000, n); chk("hit_stall_cycles", n, 0);
        exp_req.push_back(64'h1080); exp_val.push_back(64'h00001080_FFFFEF7F);
        fetch(64'h1080, n); chk("conflict_stall_1080", n, 4);
        exp_req.push_back(64'h1000); exp_val.push_back(64'h00000013_00000013);
        fetch(64'h1000, n); chk("conflict_stall_1000", n, 4);
        exp_req.push_back(64'h1080); exp_val.push_back(64'h00001080_FFFFEF7F);
        fetch(64'h1080, n); chk("evict_stall_1080", n, 4);

        // 3: backpressure while the PC moves on
        mem_req_ready_in = 1'b0;
        exp_req.push_back(64'h1000);
        instr_address_in = 64'h1000; instr_read_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            instr_address_in = 64'h2000;
            @(negedge clk);
            chk("bp_req_valid", {63'd0, mem_req_valid_out}, 64'd1);
        end
        @(posedge clk); #1;
        mem_req_ready_in = 1'b1;
        exp_req.push_back(64'h2000); exp_val.push_back(64'h00002000_FFFFDFFF);
        wait_hit(n);
        @(posedge clk); #1;
        instr_read_in = 1'b0;

        // 4: invalidate while waiting for the response
        exp_req.push_back(64'h1008); exp_val.push_back(64'h00001008_FFFFEFF7);
        fetch(64'h1008, n); chk("fill_1008_stall", n, 4);
        resp_lat = 3;
        exp_req.push_back(64'h3000); exp_req.push_back(64'h3000);
        exp_val.push_back(64'h00003000_FFFFCFFF);
        instr_address_in = 64'h3000; instr_read_in = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (mem_req_valid_out && mem_req_ready_in) got = 1;
        end
        if (!got) unexpected("accept_timeout");
        @(posedge clk); #1;
        invalidate_in = 1'b1;
        @(posedge clk); #1;
        invalidate_in = 1'b0;
        wait_hit(n);
        @(posedge clk); #1;
        instr_read_in = 1'b0;
        resp_lat = 1;
        exp_req.push_back(64'h1008); exp_val.push_back(64'h00001008_FFFFEFF7);
        fetch(64'h1008, n); chk("post_inval_stall", n, 4);

        // 5: bus error, fault pulse, re-request
        err_tok++;
        exp_req.push_back(64'h1010); exp_req.push_back(64'h1010);
        exp_val.push_back(64'h00001010_FFFFEFEF);
        exp_flt++;
        fetch(64'h1010, n); chk("err_stall_cycles", n, 8);

        // 6: asynchronous reset during REQ
        mem_req_ready_in = 1'b0;
        exp_req.push_back(64'h1018);
        instr_address_in = 64'h1018; instr_read_in = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("req_before_reset", {63'd0, mem_req_valid_out}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_valid", {63'd0, mem_req_valid_out}, 64'd0);
        chk("async_stall", {63'd0, instr_stall_out}, 64'd1);
        chk("async_fault", {63'd0, instr_fault_out}, 64'd0);
        exp_req.delete();
        instr_read_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_req_ready_in = 1'b1;
        stray_cnt++;
        repeat (3) begin @(posedge clk); #1; end
        exp_req.push_back(64'h3000); exp_val.push_back(64'h00003000_FFFFCFFF);
        fetch(64'h3000, n); chk("post_reset_stall", n, 4);

        repeat (2) begin @(posedge clk); #1; end
        chk("queues_drained", exp_req.size() + exp_val.size() + exp_flt, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
